opsel_alu: RTL
==============

OPSEL_ALU -- requirements
Module: opsel_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 5: operand width, legal range 2..16.
REQ-002 SHALL have parameter RANGE_LO, default 10: lower bound for the RANGE op, inclusive.
REQ-003 SHALL have parameter RANGE_HI, default 20: upper bound for the RANGE op, inclusive; RANGE_LO <= RANGE_HI.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: operands and op are valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept a command.
REQ-008 SHALL have port op, input, 3: operation select.
REQ-009 SHALL have port p, input, WIDTH: operand P.
REQ-010 SHALL have port q, input, WIDTH: operand Q.
REQ-011 SHALL have port out_valid, output, 1: result is valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port r, output, 2*WIDTH: result, zero-extended unless stated otherwise.
REQ-014 SHALL have port zero, output, 1: high when r == 0 while out_valid is high.

Function
REQ-015 SHALL use three states: IDLE, MUL, DONE.
REQ-016 SHALL drive in_ready high only in IDLE and out_valid high only in DONE.
REQ-017 SHALL accept a command on a rising edge where in_valid && in_ready, capturing op, p and q; p and q are ignored at all other times.
REQ-018 SHALL, on accepting op 0, enter MUL; on any other op, compute r and enter DONE on the same edge, giving 1-cycle latency.
REQ-019 SHALL implement op 0 (MUL) as unsigned shift-add over exactly WIDTH MUL cycles, with r = p*q at full 2*WIDTH width and out_valid rising WIDTH+1 edges after the accept edge.
REQ-020 SHALL implement op 1 (SHR) as r = p >> q, logical; q >= WIDTH gives 0.
REQ-021 SHALL implement op 2 (ADD) as r = p + q, with the carry in bit WIDTH.
REQ-022 SHALL implement op 3 (NAND) as r[WIDTH-1:0] = ~(p & q), with upper bits 0.
REQ-023 SHALL implement op 4 (ROTL) as p rotated left by (q mod WIDTH) within WIDTH bits.
REQ-024 SHALL implement op 5 (MAX) as r = (p > q) ? p : q, unsigned.
REQ-025 SHALL implement op 6 (RANGE) as r = 1 when RANGE_LO <= q <= RANGE_HI, else 0.
REQ-026 SHALL implement op 7 (PARITY) as r = XOR-reduction of p.
REQ-027 SHALL, in DONE, hold r, zero and out_valid stable until out_ready is high at a rising edge, then return to IDLE; there is no accept on that edge.
REQ-028 SHALL ignore in_valid in MUL and DONE; a new command needs in_ready first.
REQ-029 SHALL allow out_ready to be high before DONE with no effect.
REQ-030 SHALL never change state, r or the iteration counter in MUL in response to in_valid or out_ready.

Reset
REQ-031 SHALL, while rst_n is low and regardless of clk, force state IDLE, in_ready 1, out_valid 0, r 0, zero 0, and clear the iteration counter and partial product.
REQ-032 SHALL, on reset asserted mid-MUL or in DONE, discard the operation and emit no result after release.
REQ-033 SHALL accept a command on the first rising edge after rst_n deasserts.

Verification
REQ-034 SHALL cover MUL with WIDTH=5, p=31, q=31 -> r=961, out_valid rises 6 edges after accept, in_ready low throughout.
REQ-035 SHALL cover ADD p=31, q=6 -> r=37 one edge after accept; NAND p=5'b10110, q=5'b11100 -> r=5'b01011.
REQ-036 SHALL cover ROTL p=5'b10110, q=3 -> r=5'b10101; q=8 -> rotate by 3, same r; SHR p=31, q=5 -> r=0, zero=1.
REQ-037 SHALL cover RANGE q=10 -> 1, q=20 -> 1, q=9 -> 0, q=21 -> 0; MAX p=11, q=4 -> 11; PARITY p=5'b10110 -> 1.
REQ-038 SHALL cover backpressure: out_ready held low 3 cycles after a result -> r stable, in_ready 0, in_valid ignored; out_ready high -> IDLE next edge.
REQ-039 SHALL cover rst_n pulsed low mid-MUL, cycle 3 -> out_valid stays 0, in_ready 1 immediately; a following ADD completes normally.

Source files
------------

// File: rtl/opsel_alu.sv
// opsel_alu: 8-op multi-cycle ALU with valid/ready handshake on both sides.
// Ports: clk, rst_n, in_valid/in_ready, op, p, q, out_valid/out_ready, r, zero.
module opsel_alu #(
  parameter int WIDTH    = 5,
  parameter int RANGE_LO = 10,
  parameter int RANGE_HI = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r,
  output logic               zero
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WL      = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    CNT_END = CW'(WIDTH);
  localparam logic [31:0]      LO32    = RANGE_LO;
  localparam logic [31:0]      HI32    = RANGE_HI;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [W2-1:0]   r_q;
  logic            zero_q;
  logic [CW-1:0]   cnt_q;
  logic [W2-1:0]   acc_q;
  logic [W2-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;

  logic [W2-1:0]    alu_d;
  logic [WIDTH-1:0] amt;
  logic [W2-1:0]    dbl;
  logic [WIDTH-1:0] nand_w;
  logic [WIDTH-1:0] shr_w;
  logic [WIDTH-1:0] max_w;
  logic [31:0]      q32;
  logic             in_rng;

  always_comb begin
    alu_d  = '0;
    amt    = q % WL;
    // Upper half of {p,p} shifted left is p rotated left by amt.
    dbl    = {p, p} << amt;
    nand_w = ~(p & q);
    shr_w  = p >> q;
    max_w  = (p > q) ? p : q;
    q32    = {{(32 - WIDTH){1'b0}}, q};
    in_rng = (q32 >= LO32) && (q32 <= HI32);
    unique case (op)
      3'd1: if (q < WL) alu_d = {{WIDTH{1'b0}}, shr_w};
      3'd2: alu_d = {{WIDTH{1'b0}}, p} + {{WIDTH{1'b0}}, q};
      3'd3: alu_d = {{WIDTH{1'b0}}, nand_w};
      3'd4: alu_d = {{WIDTH{1'b0}}, dbl[W2-1:WIDTH]};
      3'd5: alu_d = {{WIDTH{1'b0}}, max_w};
      3'd6: alu_d = {{(W2-1){1'b0}}, in_rng};
      3'd7: alu_d = {{(W2-1){1'b0}}, ^p};
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (op == 3'd0) begin
              mcand_q  <= {{WIDTH{1'b0}}, p};
              mplier_q <= q;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              r_q     <= alu_d;
              zero_q  <= (alu_d == '0);
              state_q <= S_DONE;
            end
          end
        end
        S_MUL: begin
          // WIDTH shift-add steps, then one cycle to publish the product.
          if (cnt_q == CNT_END) begin
            r_q     <= acc_q;
            zero_q  <= (acc_q == '0);
            state_q <= S_DONE;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            zero_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign r         = r_q;
  assign zero      = zero_q;

endmodule
